// File: rtl/bullcow_pkg.sv
// -----------------------------------------------------------------------------
// bullcow_pkg
// Shared types for the Bulls & Cows turn controller and its serial scorer.
//   state_t  : controller state codes (visible on game_state)
//   digit_t  : one BCD digit
//   number_t : four BCD digits, digit0 in [3:0] ... digit3 in [15:12]
//   is_valid_number() : every digit <= 9 and all four pairwise distinct
// -----------------------------------------------------------------------------
package bullcow_pkg;

   typedef enum logic [2:0] {
      ST_SETUP1 = 3'b000,
      ST_SETUP2 = 3'b001,
      ST_GUESS1 = 3'b010,
      ST_GUESS2 = 3'b011,
      ST_SCORE  = 3'b100,
      ST_END    = 3'b111
   } state_t;

   typedef logic [3:0]      digit_t;
   typedef logic [3:0][3:0] number_t;

   function automatic logic is_valid_number(input number_t n);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (n[i] > 4'd9) ok = 1'b0;
         for (int j = i + 1; j < 4; j++) begin
            if (n[i] == n[j]) ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/bullcow_turn_ctrl_if.sv
// -----------------------------------------------------------------------------
// bullcow_turn_ctrl_if
// Board-side bundle of the turn controller.
//   enter, SW            : key level and four BCD digits from the board
//   game_state           : current state code
//   bull_count/cow_count : result of the last scored guess
//   guess_confirmed      : score available, cleared by the next accepted entry
//   invalid_entry        : one-cycle pulse on a rejected entry
//   timeout              : one-cycle pulse on a forfeited turn
//   turns_left           : remaining guesses of the relevant player
//   J1_points/J2_points  : saturating win counters
// Modports: master drives the inputs (board / bench), slave is the controller.
// -----------------------------------------------------------------------------
interface bullcow_turn_ctrl_if;

   logic        enter;
   logic [15:0] SW;
   logic [2:0]  game_state;
   logic [2:0]  bull_count;
   logic [2:0]  cow_count;
   logic        guess_confirmed;
   logic        invalid_entry;
   logic        timeout;
   logic [3:0]  turns_left;
   logic [7:0]  J1_points;
   logic [7:0]  J2_points;

   modport master (
      output enter, SW,
      input  game_state, bull_count, cow_count, guess_confirmed,
             invalid_entry, timeout, turns_left, J1_points, J2_points
   );

   modport slave (
      input  enter, SW,
      output game_state, bull_count, cow_count, guess_confirmed,
             invalid_entry, timeout, turns_left, J1_points, J2_points
   );

endinterface

// File: rtl/bullcow_scorer.sv
// -----------------------------------------------------------------------------
// bullcow_scorer
// Serial bulls/cows scorer: one digit index per cycle over four cycles.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : snapshots guess/secret and begins a new scoring pass
//   guess/secret : numbers to compare
//   busy         : high while digits 0..3 are being evaluated
//   done         : high in the cycle evaluating digit 3
//   bulls/cows   : running totals including the digit under evaluation, so
//                  they hold the final result while done is high
// -----------------------------------------------------------------------------
module bullcow_scorer
   import bullcow_pkg::*;
(
   input  logic    clock,
   input  logic    reset,
   input  logic    start,
   input  number_t guess,
   input  number_t secret,
   output logic    busy,
   output logic    done,
   output logic [2:0] bulls,
   output logic [2:0] cows
);

   logic [1:0] idx;
   logic [2:0] bull_acc;
   logic [2:0] cow_acc;
   number_t    guess_q;
   number_t    secret_q;

   digit_t     g_digit;
   logic       bull_hit;
   logic       cow_hit;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      g_digit  = guess_q[idx];
      bull_hit = 1'b0;
      cow_hit  = 1'b0;
      if (busy) begin
         if (g_digit == secret_q[idx]) begin
            bull_hit = 1'b1;
         end else begin
            // A digit that is not a bull counts as at most one cow.
            for (int j = 0; j < 4; j++) begin
               if (j != int'(idx) && g_digit == secret_q[j]) cow_hit = 1'b1;
            end
         end
      end
   end

   assign done  = busy && (idx == 2'd3);
   assign bulls = bull_acc + {2'b00, bull_hit};
   assign cows  = cow_acc  + {2'b00, cow_hit};

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples values from before the edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy     <= 1'b0;
         idx      <= 2'd0;
         bull_acc <= 3'd0;
         cow_acc  <= 3'd0;
         // NOTE: the snapshots are cleared too, so a reset mid-pass leaves no
         // stale digits behind.
         guess_q  <= '0;
         secret_q <= '0;
      end else if (start) begin
         busy     <= 1'b1;
         idx      <= 2'd0;
         bull_acc <= 3'd0;
         cow_acc  <= 3'd0;
         guess_q  <= guess;
         secret_q <= secret;
      end else if (busy) begin
         bull_acc <= bulls;
         cow_acc  <= cows;
         idx      <= idx + 2'd1;
         if (idx == 2'd3) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/bullcow_turn_ctrl.sv
// -----------------------------------------------------------------------------
// bullcow_turn_ctrl
// Two-player Bulls & Cows turn controller: secret entry, alternating guesses,
// serial scoring, per-player turn limits, optional per-turn timeout, points.
//   MAX_TURNS      : guesses per player per round (1..15)
//   TIMEOUT_CYCLES : cycles allowed per guess turn, 0 disables (0..2^24-1)
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   bus            : board-side signals, see bullcow_turn_ctrl_if
// -----------------------------------------------------------------------------
module bullcow_turn_ctrl
   import bullcow_pkg::*;
#(
   parameter int MAX_TURNS      = 10,
   parameter int TIMEOUT_CYCLES = 0
)(
   input  logic clock,
   input  logic reset,
   bullcow_turn_ctrl_if.slave bus
);

   localparam logic [2:0] S_SETUP1 = ST_SETUP1;
   localparam logic [2:0] S_SETUP2 = ST_SETUP2;
   localparam logic [2:0] S_GUESS1 = ST_GUESS1;
   localparam logic [2:0] S_GUESS2 = ST_GUESS2;
   localparam logic [2:0] S_SCORE  = ST_SCORE;
   localparam logic [2:0] S_END    = ST_END;

   localparam logic [3:0]  MAX_T    = 4'(MAX_TURNS);
   localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

   logic [2:0]  state;
   logic        prev_enter;
   logic        enter_edge;
   number_t     sw_num;
   logic        sw_valid;

   number_t     magic_j1;
   number_t     magic_j2;
   number_t     guess_q;
   logic        j2_turn;      // guesser is J2 (in SCORE: J2 just guessed)
   logic [3:0]  turns_j1;
   logic [3:0]  turns_j2;
   logic [23:0] tmo_cnt;
   logic        start_q;

   logic [2:0]  bull_q;
   logic [2:0]  cow_q;
   logic        confirmed_q;
   logic        invalid_q;
   logic        timeout_q;
   logic [7:0]  points_j1;
   logic [7:0]  points_j2;

   logic        in_guess;
   logic        tmo_hit;
   logic        accept;
   logic        reject;
   logic [3:0]  own_turns;
   logic [3:0]  own_dec;
   logic [3:0]  other_turns;

   logic        sc_busy;
   logic        sc_done;
   logic [2:0]  sc_bulls;
   logic [2:0]  sc_cows;

   bullcow_scorer u_scorer (
      .clock  (clock),
      .reset  (reset),
      .start  (start_q),
      .guess  (guess_q),
      .secret (j2_turn ? magic_j1 : magic_j2),
      .busy   (sc_busy),
      .done   (sc_done),
      .bulls  (sc_bulls),
      .cows   (sc_cows)
   );

   assign sw_num      = bus.SW;
   assign sw_valid    = is_valid_number(sw_num);
   assign enter_edge  = bus.enter & ~prev_enter;
   assign in_guess    = (state == S_GUESS1) || (state == S_GUESS2);
   assign accept      = enter_edge && sw_valid && !sc_busy;
   assign reject      = enter_edge && !sw_valid;
   // A valid edge in the same cycle takes priority over an expiring turn.
   assign tmo_hit     = TMO_EN && in_guess && (tmo_cnt == TMO_LAST) && !accept;
   assign own_turns   = j2_turn ? turns_j2 : turns_j1;
   assign other_turns = j2_turn ? turns_j1 : turns_j2;
   assign own_dec     = (own_turns != 4'd0) ? own_turns - 4'd1 : 4'd0;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_SETUP1;
         prev_enter  <= 1'b1;      // a key held through reset must not fire
         magic_j1    <= '0;
         magic_j2    <= '0;
         guess_q     <= '0;
         j2_turn     <= 1'b0;
         turns_j1    <= MAX_T;
         turns_j2    <= MAX_T;
         tmo_cnt     <= '0;
         start_q     <= 1'b0;
         bull_q      <= 3'd0;
         cow_q       <= 3'd0;
         confirmed_q <= 1'b0;
         invalid_q   <= 1'b0;
         timeout_q   <= 1'b0;
         points_j1   <= 8'd0;
         points_j2   <= 8'd0;
      end else begin
         prev_enter <= bus.enter;
         invalid_q  <= 1'b0;
         timeout_q  <= 1'b0;
         start_q    <= 1'b0;

         case (state)
            S_SETUP1: begin
               if (enter_edge) begin
                  if (sw_valid) begin
                     magic_j1 <= sw_num;
                     state    <= S_SETUP2;
                  end else begin
                     invalid_q <= 1'b1;
                  end
               end
            end

            S_SETUP2: begin
               if (enter_edge) begin
                  if (sw_valid) begin
                     magic_j2 <= sw_num;
                     turns_j1 <= MAX_T;
                     turns_j2 <= MAX_T;
                     j2_turn  <= 1'b0;
                     tmo_cnt  <= '0;
                     state    <= S_GUESS1;
                  end else begin
                     invalid_q <= 1'b1;
                  end
               end
            end

            S_GUESS1, S_GUESS2: begin
               if (reject) invalid_q <= 1'b1;
               if (accept || tmo_hit) begin
                  if (j2_turn) turns_j2 <= own_dec;
                  else         turns_j1 <= own_dec;
               end
               if (accept) begin
                  guess_q     <= sw_num;
                  confirmed_q <= 1'b0;
                  start_q     <= 1'b1;
                  state       <= S_SCORE;
               end else if (tmo_hit) begin
                  timeout_q <= 1'b1;
                  tmo_cnt   <= '0;
                  if (own_dec == 4'd0 && other_turns == 4'd0) begin
                     state <= S_END;
                  end else begin
                     j2_turn <= ~j2_turn;
                     state   <= j2_turn ? S_GUESS1 : S_GUESS2;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 24'd1;
               end
            end

            S_SCORE: begin
               // Enter edges are dropped here; nothing is queued.
               if (sc_done) begin
                  bull_q      <= sc_bulls;
                  cow_q       <= sc_cows;
                  confirmed_q <= 1'b1;
                  if (sc_bulls == 3'd4) begin
                     if (j2_turn) begin
                        if (points_j2 != 8'hFF) points_j2 <= points_j2 + 8'd1;
                     end else begin
                        if (points_j1 != 8'hFF) points_j1 <= points_j1 + 8'd1;
                     end
                     state <= S_END;
                  end else if (turns_j1 == 4'd0 && turns_j2 == 4'd0) begin
                     state <= S_END;
                  end else begin
                     j2_turn <= ~j2_turn;
                     tmo_cnt <= '0;
                     state   <= j2_turn ? S_GUESS1 : S_GUESS2;
                  end
               end
            end

            S_END: begin
               if (enter_edge) begin
                  bull_q      <= 3'd0;
                  cow_q       <= 3'd0;
                  confirmed_q <= 1'b0;
                  state       <= S_SETUP1;
               end
            end

            default: state <= S_SETUP1;
         endcase
      end
   end

   assign bus.game_state      = state;
   assign bus.bull_count      = bull_q;
   assign bus.cow_count       = cow_q;
   assign bus.guess_confirmed = confirmed_q;
   assign bus.invalid_entry   = invalid_q;
   assign bus.timeout         = timeout_q;
   assign bus.turns_left      = (in_guess || state == S_SCORE) ? own_turns : MAX_T;
   assign bus.J1_points       = points_j1;
   assign bus.J2_points       = points_j2;

endmodule

// File: tb/tb_bullcow_turn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bullcow_turn_ctrl
// Three controller instances: index 0 default (10 turns, no timeout),
// index 1 with a 20-cycle turn timeout, index 2 limited to 2 turns.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_bullcow_turn_ctrl;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   logic        enter_v [3];
   logic [15:0] sw_v    [3];

   logic [2:0] st  [3];
   logic [2:0] bc  [3];
   logic [2:0] cc  [3];
   logic       gc  [3];
   logic       inv [3];
   logic       tmo [3];
   logic [3:0] tl  [3];
   logic [7:0] p1  [3];
   logic [7:0] p2  [3];

   bullcow_turn_ctrl_if if_a ();
   bullcow_turn_ctrl_if if_t ();
   bullcow_turn_ctrl_if if_m ();

   bullcow_turn_ctrl #(.MAX_TURNS(10), .TIMEOUT_CYCLES(0))
      dut_a (.clock(clock), .reset(reset), .bus(if_a));
   bullcow_turn_ctrl #(.MAX_TURNS(10), .TIMEOUT_CYCLES(20))
      dut_t (.clock(clock), .reset(reset), .bus(if_t));
   bullcow_turn_ctrl #(.MAX_TURNS(2), .TIMEOUT_CYCLES(0))
      dut_m (.clock(clock), .reset(reset), .bus(if_m));

   assign if_a.enter = enter_v[0];  assign if_a.SW = sw_v[0];
   assign if_t.enter = enter_v[1];  assign if_t.SW = sw_v[1];
   assign if_m.enter = enter_v[2];  assign if_m.SW = sw_v[2];

   assign st[0] = if_a.game_state;      assign st[1] = if_t.game_state;      assign st[2] = if_m.game_state;
   assign bc[0] = if_a.bull_count;      assign bc[1] = if_t.bull_count;      assign bc[2] = if_m.bull_count;
   assign cc[0] = if_a.cow_count;       assign cc[1] = if_t.cow_count;       assign cc[2] = if_m.cow_count;
   assign gc[0] = if_a.guess_confirmed; assign gc[1] = if_t.guess_confirmed; assign gc[2] = if_m.guess_confirmed;
   assign inv[0] = if_a.invalid_entry;  assign inv[1] = if_t.invalid_entry;  assign inv[2] = if_m.invalid_entry;
   assign tmo[0] = if_a.timeout;        assign tmo[1] = if_t.timeout;        assign tmo[2] = if_m.timeout;
   assign tl[0] = if_a.turns_left;      assign tl[1] = if_t.turns_left;      assign tl[2] = if_m.turns_left;
   assign p1[0] = if_a.J1_points;       assign p1[1] = if_t.J1_points;       assign p1[2] = if_m.J1_points;
   assign p2[0] = if_a.J2_points;       assign p2[1] = if_t.J2_points;       assign p2[2] = if_m.J2_points;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Raise enter with sw for one sampling edge, then release it.
   task automatic press(input int k, input logic [15:0] sw);
      sw_v[k]    = sw;
      enter_v[k] = 1'b1;
      tick(1);
      enter_v[k] = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         enter_v[k] = 1'b1;
         sw_v[k]    = 16'h1234;   // valid, so a spurious edge would advance
      end
      tick(3);
      reset = 1'b0;
      tick(5);
      for (int k = 0; k < 3; k++) begin
         n_tests++; if (st[k] !== 3'b000) begin n_fail++; $display("FAIL reset_state[%0d] got %b want 000", k, st[k]); end
         n_tests++; if (bc[k] !== 3'd0 || cc[k] !== 3'd0 || gc[k] !== 1'b0) begin n_fail++; $display("FAIL reset_counts[%0d] got b=%0d c=%0d gc=%b want 0 0 0", k, bc[k], cc[k], gc[k]); end
         n_tests++; if (p1[k] !== 8'd0 || p2[k] !== 8'd0 || inv[k] !== 1'b0 || tmo[k] !== 1'b0) begin n_fail++; $display("FAIL reset_flags[%0d] got p1=%0d p2=%0d inv=%b tmo=%b want 0", k, p1[k], p2[k], inv[k], tmo[k]); end
      end
      n_tests++; if (tl[0] !== 4'd10) begin n_fail++; $display("FAIL reset_turns_a got %0d want 10", tl[0]); end
      n_tests++; if (tl[2] !== 4'd2)  begin n_fail++; $display("FAIL reset_turns_m got %0d want 2", tl[2]); end
      for (int k = 0; k < 3; k++) enter_v[k] = 1'b0;
      tick(1);
   endtask

   task automatic test_setup_entry;
      press(0, 16'h1123);
      n_tests++; if (inv[0] !== 1'b1 || st[0] !== 3'b000) begin n_fail++; $display("FAIL setup_dup inv=%b st=%b want 1 000", inv[0], st[0]); end
      tick(1);
      n_tests++; if (inv[0] !== 1'b0) begin n_fail++; $display("FAIL setup_inv_pulse got %b want 0", inv[0]); end
      press(0, 16'h12A4);
      n_tests++; if (inv[0] !== 1'b1 || st[0] !== 3'b000) begin n_fail++; $display("FAIL setup_nonbcd inv=%b st=%b want 1 000", inv[0], st[0]); end
      tick(1);
      press(0, 16'h1234);
      n_tests++; if (inv[0] !== 1'b0 || st[0] !== 3'b001) begin n_fail++; $display("FAIL setup_j1 inv=%b st=%b want 0 001", inv[0], st[0]); end
      tick(1);
      press(0, 16'h5678);
      n_tests++; if (st[0] !== 3'b010 || tl[0] !== 4'd10) begin n_fail++; $display("FAIL setup_j2 st=%b tl=%0d want 010 10", st[0], tl[0]); end
      tick(1);
   endtask

   task automatic test_score_latency;
      press(0, 16'h5687);                          // edge T
      n_tests++; if (st[0] !== 3'b100 || tl[0] !== 4'd9 || gc[0] !== 1'b0) begin n_fail++; $display("FAIL score_enter st=%b tl=%0d gc=%b want 100 9 0", st[0], tl[0], gc[0]); end
      tick(1);                                     // T+1, enter low
      sw_v[0] = 16'h1234; enter_v[0] = 1'b1;
      tick(1);                                     // T+2, edge in SCORE
      enter_v[0] = 1'b0;
      tick(2);                                     // T+4
      n_tests++; if (st[0] !== 3'b100 || gc[0] !== 1'b0) begin n_fail++; $display("FAIL score_t4 st=%b gc=%b want 100 0", st[0], gc[0]); end
      tick(1);                                     // T+5
      n_tests++; if (bc[0] !== 3'd2 || cc[0] !== 3'd2) begin n_fail++; $display("FAIL score_5687 got b=%0d c=%0d want 2 2", bc[0], cc[0]); end
      n_tests++; if (st[0] !== 3'b011 || gc[0] !== 1'b1 || tl[0] !== 4'd10) begin n_fail++; $display("FAIL score_next st=%b gc=%b tl=%0d want 011 1 10", st[0], gc[0], tl[0]); end
      tick(3);
      n_tests++; if (st[0] !== 3'b011) begin n_fail++; $display("FAIL score_drop_edge st=%b want 011", st[0]); end
   endtask

   task automatic test_win;
      press(0, 16'h1234);
      n_tests++; if (st[0] !== 3'b100 || tl[0] !== 4'd9) begin n_fail++; $display("FAIL win_enter st=%b tl=%0d want 100 9", st[0], tl[0]); end
      tick(5);
      n_tests++; if (bc[0] !== 3'd4 || cc[0] !== 3'd0 || st[0] !== 3'b111) begin n_fail++; $display("FAIL win_score b=%0d c=%0d st=%b want 4 0 111", bc[0], cc[0], st[0]); end
      n_tests++; if (p2[0] !== 8'd1 || p1[0] !== 8'd0 || tl[0] !== 4'd10) begin n_fail++; $display("FAIL win_points p1=%0d p2=%0d tl=%0d want 0 1 10", p1[0], p2[0], tl[0]); end
      tick(1);
      press(0, 16'hFFFF);
      n_tests++; if (st[0] !== 3'b000 || p2[0] !== 8'd1 || gc[0] !== 1'b0) begin n_fail++; $display("FAIL end_exit st=%b p2=%0d gc=%b want 000 1 0", st[0], p2[0], gc[0]); end
      n_tests++; if (bc[0] !== 3'd0 || cc[0] !== 3'd0 || inv[0] !== 1'b0) begin n_fail++; $display("FAIL end_clear b=%0d c=%0d inv=%b want 0 0 0", bc[0], cc[0], inv[0]); end
      tick(1);
   endtask

   task automatic test_timeout;
      press(1, 16'h1234);
      tick(1);
      press(1, 16'h5678);                          // GUESS1 entry E
      tick(19);
      n_tests++; if (st[1] !== 3'b010 || tmo[1] !== 1'b0) begin n_fail++; $display("FAIL tmo_early st=%b tmo=%b want 010 0", st[1], tmo[1]); end
      tick(1);                                     // E+20
      n_tests++; if (tmo[1] !== 1'b1 || st[1] !== 3'b011 || tl[1] !== 4'd10) begin n_fail++; $display("FAIL tmo_fire tmo=%b st=%b tl=%0d want 1 011 10", tmo[1], st[1], tl[1]); end
      n_tests++; if (bc[1] !== 3'd0 || gc[1] !== 1'b0) begin n_fail++; $display("FAIL tmo_keep b=%0d gc=%b want 0 0", bc[1], gc[1]); end
      tick(1);
      n_tests++; if (tmo[1] !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse got %b want 0", tmo[1]); end
      tick(19);                                    // E+40, J2 forfeits
      n_tests++; if (tmo[1] !== 1'b1 || st[1] !== 3'b010 || tl[1] !== 4'd9) begin n_fail++; $display("FAIL tmo_j2 tmo=%b st=%b tl=%0d want 1 010 9", tmo[1], st[1], tl[1]); end
      tick(19);                                    // E2+19
      sw_v[1] = 16'h5678; enter_v[1] = 1'b1;
      tick(1);                                     // E2+20: edge and timeout coincide
      enter_v[1] = 1'b0;
      n_tests++; if (st[1] !== 3'b100 || tmo[1] !== 1'b0 || tl[1] !== 4'd8) begin n_fail++; $display("FAIL tmo_edge_wins st=%b tmo=%b tl=%0d want 100 0 8", st[1], tmo[1], tl[1]); end
      tick(5);
      n_tests++; if (st[1] !== 3'b111 || bc[1] !== 3'd4 || p1[1] !== 8'd1) begin n_fail++; $display("FAIL tmo_win st=%b b=%0d p1=%0d want 111 4 1", st[1], bc[1], p1[1]); end
   endtask

   task automatic test_turn_limit;
      logic [15:0] g  [4] = '{16'h8765, 16'h4321, 16'h5679, 16'h2134};
      logic [2:0]  eb [4] = '{3'd0, 3'd0, 3'd3, 3'd2};
      logic [2:0]  ec [4] = '{3'd4, 3'd4, 3'd0, 3'd2};
      logic [2:0]  es [4] = '{3'b011, 3'b010, 3'b011, 3'b111};
      logic [3:0]  et [4] = '{4'd2, 4'd1, 4'd1, 4'd2};
      press(2, 16'h1234);
      tick(1);
      press(2, 16'h5678);
      n_tests++; if (st[2] !== 3'b010 || tl[2] !== 4'd2) begin n_fail++; $display("FAIL limit_start st=%b tl=%0d want 010 2", st[2], tl[2]); end
      tick(1);
      for (int i = 0; i < 4; i++) begin
         press(2, g[i]);
         tick(5);
         n_tests++; if (bc[2] !== eb[i] || cc[2] !== ec[i]) begin n_fail++; $display("FAIL limit_score%0d got b=%0d c=%0d want %0d %0d", i, bc[2], cc[2], eb[i], ec[i]); end
         n_tests++; if (st[2] !== es[i] || tl[2] !== et[i]) begin n_fail++; $display("FAIL limit_state%0d st=%b tl=%0d want %b %0d", i, st[2], tl[2], es[i], et[i]); end
         tick(1);
      end
      n_tests++; if (p1[2] !== 8'd0 || p2[2] !== 8'd0) begin n_fail++; $display("FAIL limit_draw p1=%0d p2=%0d want 0 0", p1[2], p2[2]); end
   endtask

   task automatic win_round_j1;
      press(0, 16'h1234);
      tick(1);
      press(0, 16'h5678);
      tick(1);
      press(0, 16'h5678);
      tick(5);
   endtask

   task automatic test_points_saturate;
      for (int r = 0; r < 255; r++) begin
         win_round_j1();
         tick(1);
         press(0, 16'h0000);
         tick(1);
      end
      n_tests++; if (p1[0] !== 8'd255 || p2[0] !== 8'd1 || st[0] !== 3'b000) begin n_fail++; $display("FAIL sat_reach p1=%0d p2=%0d st=%b want 255 1 000", p1[0], p2[0], st[0]); end
      win_round_j1();
      n_tests++; if (p1[0] !== 8'd255 || st[0] !== 3'b111 || bc[0] !== 3'd4) begin n_fail++; $display("FAIL sat_hold p1=%0d st=%b b=%0d want 255 111 4", p1[0], st[0], bc[0]); end
   endtask

   initial begin
      test_reset();
      test_setup_entry();
      test_score_latency();
      test_win();
      test_timeout();
      test_turn_limit();
      test_points_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/bullcow_turn_ctrl.md
# bullcow_turn_ctrl

Turn controller for the two-player Bulls & Cows game. It sequences secret entry, alternating guesses, multi-cycle scoring, turn limits, per-turn timeouts and score keeping. It sits between the board inputs (enter key, SW[15:0]) and the display logic. It replaces single-cycle scoring with a serial scorer sub-module.

## Interface
- MAX_TURNS, default 10: guesses allowed per player per round; legal range 1..15.
- TIMEOUT_CYCLES, default 0: cycles allowed per guess turn; 0 disables timeouts; legal range 0..2^24-1.
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- enter  in  1  raw key level; edge-detected internally
- SW  in  16  four BCD digits; digit0=SW[3:0] … digit3=SW[15:12]
- game_state  out  3  current state code
- bull_count  out  3  bulls from the last scored guess
- cow_count  out  3  cows from the last scored guess
- guess_confirmed  out  1  high from score completion until the next accepted entry
- invalid_entry  out  1  one-cycle pulse when an entry is rejected
- timeout  out  1  one-cycle pulse when a turn is forfeited
- turns_left  out  4  remaining guesses of the current guesser
- J1_points  out  8  J1 wins, saturating
- J2_points  out  8  J2 wins, saturating

## Operation
- Enter edge: edge = enter & ~prev_enter. prev_enter resets to 1, so a key held through reset does not fire.
- Valid entry: all digits ≤9 and pairwise distinct. The check is combinational on SW in the edge cycle.
- States and codes:
  - SETUP1 000: valid edge stores magic_J1 and goes to SETUP2.
  - SETUP2 001: valid edge stores magic_J2, loads both turn counters with MAX_TURNS, and goes to GUESS1.
  - GUESS1 010: J1 guesses against magic_J2.
  - GUESS2 011: J2 guesses against magic_J1.
  - SCORE 100: waits for the scorer to finish.
  - END 111: round over.
- Invalid edge in SETUP or GUESS: pulse invalid_entry, stay in state, no other change.
- Valid edge in GUESS: latch the guess, decrement the guesser's turn counter, clear guess_confirmed, pulse scorer start, go to SCORE.
- On scorer done:
  - Update bull_count and cow_count, set guess_confirmed.
  - bulls==4: go to END and increment the guesser's points (saturate at 255).
  - Otherwise, if both turn counters are 0: go to END with no points (draw).
  - Otherwise: go to the other player's GUESS state.
- Timeout: a cycle counter runs in GUESS states and clears on every state entry. When it reaches TIMEOUT_CYCLES:
  - pulse timeout and decrement the guesser's turn counter;
  - pass the turn, or go to END (draw) if both counters are then 0;
  - leave bull_count, cow_count and guess_confirmed unchanged.
- END: any enter edge goes to SETUP1 and clears bull_count, cow_count and guess_confirmed. Points are kept.
- Ignored edges: enter edges in SCORE are dropped, not queued. An invalid SW value in END is irrelevant.
- Simultaneous valid edge and timeout in the same cycle: the edge wins and the timeout is suppressed.
- turns_left:
  - In GUESS1 and GUESS2, shows the active player's counter.
  - In SCORE, shows the counter of the player who just guessed.
  - Otherwise shows MAX_TURNS.
- Scorer arithmetic: one digit index i per cycle, i=0..3.
  - bull if g[i]==s[i].
  - cow if g[i]!=s[i] and g[i]==s[j] for some j≠i, counted at most once per i.
  - Accumulators are 3 bits; maximum 4.

## Timing
- Reset values:
  - game_state=000; bull_count=0, cow_count=0; guess_confirmed=0, invalid_entry=0, timeout=0.
  - turns_left=MAX_TURNS; J1_points=0, J2_points=0.
  - Stored secrets and guesses cleared; scorer idle.
- Valid guess edge sampled at edge T:
  - game_state=100 after T.
  - Scorer iterates in cycles T+1..T+4; done pulses in the T+4 cycle.
  - After edge T+5: bull_count, cow_count, guess_confirmed and the next state are visible.
  - Total latency is 5 cycles.
- invalid_entry and timeout are registered one-cycle pulses, visible after the deciding edge.
- Timeout: game_state changes exactly TIMEOUT_CYCLES cycles after GUESS entry.
- Reset in SCORE aborts the scorer; no partial counts survive.

## Structure
- Package bullcow_pkg holds:
  - state_t enum with the codes above;
  - digit type logic [3:0];
  - number type logic [3:0][3:0].
- Sub-module bullcow_scorer:
  - Inputs: clock, reset, start, guess, secret.
  - Outputs: busy, done pulse, bulls[2:0], cows[2:0].
  - Holds the 2-bit index, the accumulators and the guess/secret snapshot.
- Controller holds: FSM, edge detect, validity check, turn counters, timeout counter, points.

## Test plan
- Reset with enter held high, release, keep enter high 5 cycles → no transition; game_state=000, all counts and points 0, turns_left=10.
- SETUP1: SW=16'h1123 edge → invalid_entry pulse, state 000. Then SW=16'h12A4 → same. Then SW=16'h1234 → state 001.
- Secrets J1=16'h1234, J2=16'h5678; J1 guesses SW=16'h5687; second enter edge during SCORE → ignored; after 5 cycles bull_count=2, cow_count=2, guess_confirmed=1, state 011, J1 turns 9.
- J2 guesses SW=16'h1234 → bull_count=4, state 111, J2_points=1; next edge → state 000, J2_points stays 1, guess_confirmed=0.
- TIMEOUT_CYCLES=20, no enter in GUESS1 → timeout pulse at cycle 20, state 011, turns_left shows J2=10; J1 counter 9. Also valid edge coincident with the 20th cycle → scored, no timeout pulse.
- MAX_TURNS=2, four wrong valid guesses → state 111 after the 4th score, points unchanged. Also J1_points preset to 255 via 255 wins → stays 255.
